fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the 8-bit `fifo_junior` between several producers. It grants one requester at a time for a bounded burst, forwards that requester's data and write strobe straight to the FIFO, and applies `fifo_full` back-pressure through per-requester ready signals. It sits directly in front of `fifo_junior`. The FIFO read side is not touched.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `DATA_W`, default 8: data width; must match the FIFO.
- `BURST_LEN`, default 4: maximum words accepted per grant; legal range 1..16.
- Clock and reset: one clock, `clk_i`. Reset `rst_i` is asynchronous and active-high.

Ports:
- `clk_i`  in  1  system clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous active-high reset.
- `req_valid_i`  in  NUM_REQ  bit n set: requester n presents a word.
- `req_data_i`  in  NUM_REQ*DATA_W  requester n data at bits [n*DATA_W +: DATA_W].
- `req_ready_o`  out  NUM_REQ  bit n set: requester n's word is taken this cycle if its valid bit is set.
- `fifo_full_i`  in  1  from FIFO `fifo_full`.
- `fifo_write_o`  out  1  to FIFO `write`.
- `fifo_data_o`  out  DATA_W  to FIFO `data_in`.
- `grant_valid_o`  out  1  a burst grant is held.
- `grant_id_o`  out  $clog2(NUM_REQ)  index of the granted requester.

## Operation
- The FSM has two states: IDLE and BURST. It holds three registers: `rr_ptr`, `grant_id`, and `burst_cnt` ($clog2(BURST_LEN)+1 bits).
- In IDLE, if any `req_valid_i` bit is set, the arbiter selects the first set bit searching from `rr_ptr` upward, wrapping modulo NUM_REQ. It registers that index as `grant_id`, clears `burst_cnt`, and moves to BURST. If no bit is set, it stays in IDLE.
- In BURST, the datapath is combinational:
  - `req_ready_o[grant_id] = !fifo_full_i`.
  - All other ready bits are 0.
  - `fifo_write_o = req_valid_i[grant_id] & !fifo_full_i`.
  - `fifo_data_o` = the granted requester's data slice.
- A transfer is any cycle with `fifo_write_o` = 1. Each transfer increments `burst_cnt`.
- The FSM leaves BURST for IDLE in either of two cases:
  - A transfer occurs with `burst_cnt == BURST_LEN-1`.
  - `req_valid_i[grant_id]` is 0. No transfer happens that cycle.
- On that exit, `rr_ptr <= (grant_id+1) mod NUM_REQ`.
- A stall (valid=1, full=1) keeps the FSM in BURST. The counter and pointer are held. A grant is never preempted.
- In IDLE, `req_ready_o`, `fifo_write_o` and `grant_valid_o` are all 0. `fifo_data_o` is 0 whenever `fifo_write_o` is 0.

## Timing
- Reset values:
  - FSM = IDLE, `rr_ptr` = 0, `grant_id_o` = 0, `burst_cnt` = 0.
  - `grant_valid_o` = 0, `req_ready_o` = 0, `fifo_write_o` = 0, `fifo_data_o` = 0.
- Arbitration latency is 1 cycle: a request seen in IDLE at edge k can transfer in the cycle after edge k.
- Back-to-back grants have a 1-cycle IDLE bubble between bursts.
- `fifo_full_i` is sampled combinationally. The arbiter never asserts a write while full is 1, so the FIFO cannot overflow through this block.
- A requester must hold valid and data stable until it sees ready.
- Dropping valid mid-burst ends the grant. Asserting valid again requires a new arbitration.
- If `rst_i` asserts mid-burst, all outputs go to reset values immediately, with no clock needed. Any partially sent burst is abandoned.
- Wrap-around: when `grant_id` = NUM_REQ-1, `rr_ptr` becomes 0.

## Configuration
- Macro: `FIFO_WR_ARBITER_STATS_EN`.
- When defined, the block adds two ports:
  - `stat_sel_i`  in  $clog2(NUM_REQ).
  - `stat_cnt_o`  out  16.
- With the macro, the block keeps one 16-bit accepted-word counter per requester:
  - The counter increments on each transfer for that requester and wraps 0xFFFF -> 0x0000.
  - All counters are cleared by reset.
  - `stat_cnt_o` is registered: it shows `counter[stat_sel_i]` one cycle after the select. A transfer in the same cycle is reflected one cycle later.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

## Test plan
- **Single requester, 6 words:** requester 0 holds valid with data 0x03..0x08, FIFO not full, BURST_LEN=4.
  - Expect 4 writes, then 1 IDLE cycle with ready=0, then 2 writes.
  - FIFO read-back is 0x03..0x08 in order.
- **All 4 requesters continuously valid:** data = 0x10+n.
  - Grants rotate 0,1,2,3,0.
  - Each grant gives exactly 4 writes, with a 1-cycle gap between grants.
- **Back-pressure:** force `fifo_full_i`=1 for 3 cycles mid-burst of requester 2.
  - `fifo_write_o` and `req_ready_o[2]` are 0 for those cycles.
  - `grant_id_o` stays 2 and the burst resumes to 4 total words.
  - No data is lost or duplicated.
- **Early release:** requester 1 drops valid after 2 words.
  - The FSM goes to IDLE.
  - The next grant goes to requester 2 if valid, even though requester 1 reasserts.
- **Async reset mid-burst:** pulse `rst_i` for 6 ps between clock edges during the third word of a burst.
  - All outputs are 0 before the next edge and `rr_ptr` is 0.
  - The first grant after reset goes to requester 0.
- **With `FIFO_WR_ARBITER_STATS_EN`:** after the rotation test, `stat_sel_i`=1 gives `stat_cnt_o`=8 one cycle later.
  - After 65 537 transfers for requester 0, its counter reads 1.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the fifo_junior write port among NUM_REQ producers in bounded bursts.
// Optional per-requester accepted-word counters are enabled with `define FIFO_WR_ARBITER_STATS_EN.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic                         fifo_full_i,
    output logic                         fifo_write_o,
    output logic [DATA_W-1:0]            fifo_data_o,
    output logic                         grant_valid_o,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id_o
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    input  logic [$clog2(NUM_REQ)-1:0]   stat_sel_i,
    output logic [15:0]                  stat_cnt_o
`endif
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(BURST_LEN) + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state_q;
    logic [IDW-1:0]    rr_ptr_q;
    logic [IDW-1:0]    grant_id_q;
    logic [CW-1:0]     burst_cnt_q;

    logic [IDW-1:0]    pick_d;
    logic              pick_vld_d;
    logic [IDW-1:0]    rr_ptr_d;
    logic              in_burst;
    logic              gnt_valid;
    logic [DATA_W-1:0] gnt_data;
    logic              xfer;
    logic              last_word;

    // Descending scan so the requester closest to rr_ptr (upward, wrapping) wins.
    always_comb begin
        pick_d     = '0;
        pick_vld_d = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (req_valid_i[idx]) begin
                pick_d     = IDW'(idx);
                pick_vld_d = 1'b1;
            end
        end
    end

    assign in_burst  = (state_q == BURST);
    assign gnt_valid = req_valid_i[grant_id_q];
    assign gnt_data  = req_data_i[int'(grant_id_q)*DATA_W +: DATA_W];
    assign xfer      = in_burst & gnt_valid & ~fifo_full_i;
    assign last_word = (burst_cnt_q == CW'(BURST_LEN - 1));
    assign rr_ptr_d  = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    always_comb begin
        req_ready_o = '0;
        if (in_burst && !fifo_full_i) begin
            req_ready_o[grant_id_q] = 1'b1;
        end
    end

    assign fifo_write_o  = xfer;
    assign fifo_data_o   = xfer ? gnt_data : '0;
    assign grant_valid_o = in_burst;
    assign grant_id_o    = grant_id_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld_d) begin
                        grant_id_q  <= pick_d;
                        burst_cnt_q <= '0;
                        state_q     <= BURST;
                    end
                end
                BURST: begin
                    // A stall (valid with full) falls through both branches and holds everything.
                    if (xfer) begin
                        burst_cnt_q <= burst_cnt_q + 1'b1;
                        if (last_word) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= rr_ptr_d;
                        end
                    end else if (!gnt_valid) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [15:0] word_cnt_q [NUM_REQ];
    logic [15:0] stat_cnt_q;

    // stat_cnt_q samples the pre-update counter, so a same-cycle transfer shows one cycle later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < NUM_REQ; n++) begin
                word_cnt_q[n] <= '0;
            end
            stat_cnt_q <= '0;
        end else begin
            if (xfer) begin
                word_cnt_q[grant_id_q] <= word_cnt_q[grant_id_q] + 16'd1;
            end
            stat_cnt_q <= word_cnt_q[stat_sel_i];
        end
    end

    assign stat_cnt_o = stat_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and scenario bench for fifo_wr_arbiter against a queue-based reference model.
// Stats checks are compiled in when FIFO_WR_ARBITER_STATS_EN is defined.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int BL  = 4;
    localparam int IW  = $clog2(N);

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      vld;
    logic [N*DW-1:0]   data;
    logic [N-1:0]      rdy;
    logic              full;
    logic              wr;
    logic [DW-1:0]     fd;
    logic              gv;
    logic [IW-1:0]     gid;
`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [IW-1:0]     stat_sel;
    logic [15:0]       stat_cnt;
`endif

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (vld),
        .req_data_i   (data),
        .req_ready_o  (rdy),
        .fifo_full_i  (full),
        .fifo_write_o (wr),
        .fifo_data_o  (fd),
        .grant_valid_o(gv),
        .grant_id_o   (gid)
`ifdef FIFO_WR_ARBITER_STATS_EN
        ,
        .stat_sel_i   (stat_sel),
        .stat_cnt_o   (stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who holds the grant (-1 = nobody), words taken in this grant, next search start.
    int        m_gnt;
    int        m_taken;
    int        m_ptr;
    int        m_words [N];
    logic [15:0] m_stat;
    bit        rnd_pause;

    byte unsigned src [N][$];
    int        pause [N];
    byte unsigned wlog [$];
    int        glog [$];
    bit        wpat [$];

    task automatic model_reset();
        m_gnt   = -1;
        m_taken = 0;
        m_ptr   = 0;
        m_stat  = 16'd0;
        for (int n = 0; n < N; n++) m_words[n] = 0;
    endtask

    task automatic drive();
        for (int n = 0; n < N; n++) begin
            vld[n] = (src[n].size() > 0) && (pause[n] == 0);
            data[n*DW +: DW] = (src[n].size() > 0) ? src[n][0] : 8'($urandom);
        end
`ifdef FIFO_WR_ARBITER_STATS_EN
        stat_sel = IW'($urandom_range(0, N - 1));
`endif
    endtask

    task automatic check_outputs();
        logic [N-1:0]  e_rdy;
        logic          e_wr;
        logic [DW-1:0] e_d;
        e_rdy = '0;
        e_wr  = 1'b0;
        e_d   = '0;
        if (m_gnt >= 0) begin
            if (!full) e_rdy[m_gnt] = 1'b1;
            e_wr = vld[m_gnt] && !full;
            if (e_wr) e_d = src[m_gnt][0];
        end
        check_val("ready", 32'(rdy), 32'(e_rdy));
        check_val("write", 32'(wr), 32'(e_wr));
        check_val("data", 32'(fd), 32'(e_d));
        check_val("grant_valid", 32'(gv), 32'(m_gnt >= 0));
        if (m_gnt >= 0) check_val("grant_id", 32'(gid), 32'(m_gnt));
`ifdef FIFO_WR_ARBITER_STATS_EN
        check_val("stat_cnt", 32'(stat_cnt), 32'(m_stat));
`endif
        wpat.push_back(wr);
        if (wr) wlog.push_back(fd);
    endtask

    task automatic model_edge();
`ifdef FIFO_WR_ARBITER_STATS_EN
        m_stat = 16'(m_words[stat_sel]);
`endif
        for (int n = 0; n < N; n++) if (pause[n] > 0) pause[n]--;
        if (m_gnt < 0) begin
            for (int k = 0; k < N; k++) begin
                if (vld[(m_ptr + k) % N]) begin
                    m_gnt   = (m_ptr + k) % N;
                    m_taken = 0;
                    glog.push_back(m_gnt);
                    break;
                end
            end
        end else if (vld[m_gnt] && !full) begin
            void'(src[m_gnt].pop_front());
            m_words[m_gnt] = (m_words[m_gnt] + 1) % 65536;
            if (rnd_pause && $urandom_range(0, 5) == 0) pause[m_gnt] = $urandom_range(1, 3);
            m_taken++;
            if (m_taken == BL) begin
                m_ptr = (m_gnt + 1) % N;
                m_gnt = -1;
            end
        end else if (!vld[m_gnt]) begin
            m_ptr = (m_gnt + 1) % N;
            m_gnt = -1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
        drive();
    endtask

    task automatic do_reset();
        for (int n = 0; n < N; n++) begin
            src[n].delete();
            pause[n] = 0;
        end
        full = 1'b0;
        drive();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_outputs();
        check_val("grant_id_rst", 32'(gid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wlog.delete();
        glog.delete();
        wpat.delete();
    endtask

    function automatic bit all_empty();
        for (int n = 0; n < N; n++) if (src[n].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_until_drained(input int budget);
        int c = 0;
        while (!(all_empty() && m_gnt < 0) && c < budget) begin
            step();
            c++;
        end
        if (c >= budget) check_val("drain_timeout", 32'd1, 32'd0);
        step();
    endtask

    task automatic run_until_words(input int cnt, input int budget);
        int c = 0;
        while (wlog.size() < cnt && c < budget) begin
            step();
            c++;
        end
        if (c >= budget) check_val("words_timeout", 32'(wlog.size()), 32'(cnt));
    endtask

    initial begin
        logic [15:0] pat;
        rst       = 1'b1;
        full      = 1'b0;
        rnd_pause = 1'b0;
        for (int n = 0; n < N; n++) pause[n] = 0;

        // Reset state and single requester with six words.
        do_reset();
        for (int i = 3; i <= 8; i++) src[0].push_back(8'(i));
        drive();
        run_until_drained(50);
        check_val("single_count", 32'(wlog.size()), 32'd6);
        for (int i = 0; i < 6 && i < wlog.size(); i++) check_val("single_data", 32'(wlog[i]), 32'(i + 3));
        while (wpat.size() > 0 && wpat[0] == 1'b0) void'(wpat.pop_front());
        pat = '0;
        for (int i = 0; i < 7 && i < wpat.size(); i++) pat[i] = wpat[i];
        check_val("single_pattern", 32'(pat), 32'b1101111);

        // All requesters continuously valid.
        do_reset();
        for (int n = 0; n < N; n++) for (int i = 0; i < 8; i++) src[n].push_back(8'(16 + n));
        drive();
        run_until_drained(100);
        check_val("rot_grants", 32'(glog.size()), 32'd8);
        for (int i = 0; i < 5 && i < glog.size(); i++) check_val("rot_order", 32'(glog[i]), 32'(i % N));
        check_val("rot_words", 32'(wlog.size()), 32'd32);

        // Back-pressure mid-burst of requester 2.
        do_reset();
        for (int i = 0; i < 4; i++) src[2].push_back(8'(8'hA0 + i));
        drive();
        run_until_words(2, 20);
        full = 1'b1;
        for (int i = 0; i < 3; i++) step();
        full = 1'b0;
        run_until_drained(30);
        check_val("bp_grants", 32'(glog.size()), 32'd1);
        check_val("bp_count", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) check_val("bp_data", 32'(wlog[i]), 32'(8'hA0 + i));

        // Early release by requester 1, then requester 2 must be served before 1 again.
        do_reset();
        src[1].push_back(8'h51);
        src[1].push_back(8'h52);
        src[2].push_back(8'h61);
        drive();
        run_until_words(2, 20);
        step();
        src[1].push_back(8'h53);
        drive();
        run_until_drained(30);
        check_val("early_grants", 32'(glog.size()), 32'd3);
        if (glog.size() >= 2) check_val("early_next", 32'(glog[1]), 32'd2);

        // Asynchronous reset during the third word of a burst.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            src[1].push_back(8'(8'h70 + i));
            src[0].push_back(8'(8'h80 + i));
        end
        drive();
        run_until_words(2, 20);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #0.006;
        rst = 1'b0;
        #0.001;
        check_val("arst_ready", 32'(rdy), 32'd0);
        check_val("arst_write", 32'(wr), 32'd0);
        check_val("arst_data", 32'(fd), 32'd0);
        check_val("arst_gvalid", 32'(gv), 32'd0);
        check_val("arst_gid", 32'(gid), 32'd0);
        model_reset();
        glog.delete();
        @(posedge clk);
        model_edge();
        #1;
        drive();
        run_until_drained(100);
        if (glog.size() > 0) check_val("arst_first", 32'(glog[0]), 32'd0);
        else check_val("arst_first_missing", 32'd1, 32'd0);

        // Randomised traffic with back-pressure and voluntary gaps.
        do_reset();
        rnd_pause = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < N; n++)
                if (src[n].size() < 3 && $urandom_range(0, 3) == 0) src[n].push_back(8'($urandom));
            full = ($urandom_range(0, 3) == 0);
            drive();
            step();
        end
        full = 1'b0;
        rnd_pause = 1'b0;
        for (int n = 0; n < N; n++) pause[n] = 0;
        drive();
        run_until_drained(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
